// File: rtl/gpio_poll_ctrl.sv
// AXI4-Lite master that configures the GPIO tri-state registers, then polls GPIO2_DATA and writes GPIO_DATA.
// Optional: define GPIO_POLL_CHANGE_ONLY_EN to skip the LED write when led_data matches the last OKAY write.
module gpio_poll_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          POLL_CYCLES = 1000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [31:0] led_data,
  output logic [31:0] btn_data,
  output logic        btn_valid,
  output logic        init_done,
  output logic        err,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    INIT_TRI1, INIT_TRI2, IDLE, RD_ADDR, RD_DATA, WR, WR_RESP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          wr_busy;
  logic          launch_wr, launch_rd;
  logic [31:0]   wr_addr, wr_data;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_rem, w_rem;
  logic          skip_wr;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid & m_axi_wready;
  assign b_hs   = m_axi_bvalid & m_axi_bready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign r_hs   = m_axi_rvalid & m_axi_rready;
  // Channel still waiting for its ready after the coming edge.
  assign aw_rem = m_axi_awvalid & ~m_axi_awready;
  assign w_rem  = m_axi_wvalid & ~m_axi_wready;

`ifdef GPIO_POLL_CHANGE_ONLY_EN
  logic [31:0] last_led;
  logic        last_vld;
  assign skip_wr = last_vld && (led_data == last_led);
`else
  assign skip_wr = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    launch_wr = 1'b0;
    launch_rd = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    case (state)
      INIT_TRI1: begin
        if (!wr_busy) begin
          launch_wr = 1'b1;
          wr_addr   = BASE_ADDR + 32'h4;
        end else if (b_hs) begin
          state_nxt = INIT_TRI2;
          launch_wr = 1'b1;
          wr_addr   = BASE_ADDR + 32'hC;
          wr_data   = '1;
        end
      end
      INIT_TRI2: if (b_hs) state_nxt = IDLE;
      IDLE: begin
        if (enable && timer == TMAX) begin
          state_nxt = RD_ADDR;
          launch_rd = 1'b1;
        end
      end
      RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          if (skip_wr) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WR;
            launch_wr = 1'b1;
            wr_addr   = BASE_ADDR;
            wr_data   = led_data;
          end
        end
      end
      WR:      if (!aw_rem && !w_rem) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = INIT_TRI1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= INIT_TRI1;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      timer         <= '0;
      wr_busy       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_araddr  <= '0;
      btn_data      <= '0;
      btn_valid     <= 1'b0;
      init_done     <= 1'b0;
      err           <= 1'b0;
`ifdef GPIO_POLL_CHANGE_ONLY_EN
      last_led      <= '0;
      last_vld      <= 1'b0;
`endif
    end else begin
      btn_valid <= 1'b0;

      if (state == IDLE && enable && timer != TMAX) timer <= timer + TW'(1);
      else                                          timer <= '0;

      if (aw_hs) m_axi_awvalid <= 1'b0;
      if (w_hs)  m_axi_wvalid  <= 1'b0;

      // bready waits until both address and data have been accepted.
      if (b_hs) begin
        m_axi_bready <= 1'b0;
        wr_busy      <= 1'b0;
        if (m_axi_bresp != 2'b00) err <= 1'b1;
        if (state == INIT_TRI2) init_done <= 1'b1;
`ifdef GPIO_POLL_CHANGE_ONLY_EN
        if (state == WR_RESP && m_axi_bresp == 2'b00) begin
          last_led <= m_axi_wdata;
          last_vld <= 1'b1;
        end
`endif
      end else if (wr_busy && !aw_rem && !w_rem) begin
        m_axi_bready <= 1'b1;
      end

      if (launch_wr) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        m_axi_awaddr  <= wr_addr;
        m_axi_wdata   <= wr_data;
        wr_busy       <= 1'b1;
      end

      if (launch_rd) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= BASE_ADDR + 32'h8;
      end
      if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b1;
      end
      if (r_hs) begin
        m_axi_rready <= 1'b0;
        if (m_axi_rresp == 2'b00) begin
          btn_data  <= m_axi_rdata;
          btn_valid <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/gpio_poll_ctrl.md
# gpio_poll_ctrl

AXI4-Lite master sequencer that owns the AXI GPIO slave at BASE_ADDR and replaces testbench-driven register access in hardware. After reset it configures the GPIO tri-state registers, then polls the push-button channel (GPIO2_DATA) every POLL_CYCLES and writes the LED channel (GPIO_DATA) from its led_data input. It sits between user logic and the GPIO slave port in design_1, on the same aclk domain.

## Interface
- BASE_ADDR, 32'h4000_0000, GPIO base address; register offsets are fixed: DATA 0x0, TRI 0x4, GPIO2_DATA 0x8, GPIO2_TRI 0xC
- POLL_CYCLES, 1000, idle cycles between poll rounds (>=2)
- aclk  in  1  system clock
- areset  in  1  synchronous reset, active-high
- enable  in  1  polling permitted when high
- led_data  in  32  value written to GPIO_DATA each round
- btn_data  out  32  last button value read with OKAY response
- btn_valid  out  1  one-cycle pulse when btn_data updates
- init_done  out  1  high once both TRI writes have completed
- err  out  1  sticky; set on any non-OKAY BRESP/RRESP
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  write address
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  read address
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data

## Operation
- States: INIT_TRI1 -> INIT_TRI2 -> IDLE -> RD_ADDR -> RD_DATA -> WR -> WR_RESP -> IDLE.
- INIT_TRI1: write 0x0000_0000 to BASE+0x4 (LEDs output). INIT_TRI2: write 0xFFFF_FFFF to BASE+0xC (buttons input). init_done rises on completion of the second write's B handshake.
- Writes (INIT and WR): awvalid and wvalid asserted in the same cycle; each deasserts the cycle after its own ready handshake; they are independent. bready asserted only after both handshakes complete; state advances on bvalid&bready.
- awprot = arprot = 3'b000; wstrb = 4'hF always.
- IDLE: timer increments while enable=1, held at 0 while enable=0. Timer == POLL_CYCLES-1 -> RD_ADDR, timer cleared.
- RD_ADDR: arvalid=1, araddr=BASE+0x8 until arready. RD_DATA: rready=1; on rvalid, if rresp==OKAY, latch rdata to btn_data and pulse btn_valid next cycle; else set err, btn_data unchanged.
- WR: awaddr=BASE+0x0, wdata=led_data sampled on entry to WR and held stable until the W handshake.
- err set by any non-OKAY response; the sequence continues regardless. Cleared only by reset.
- Deasserting enable mid-round does not abort; the round completes, then IDLE holds.

## Timing
- Reset values: all valid/ready outputs 0, addresses/wdata 0, btn_data 0, btn_valid 0, init_done 0, err 0; state INIT_TRI1; timer 0.
- First awvalid/wvalid asserted in the first cycle after areset deasserts.
- Timer expiry to arvalid: 1 cycle. R handshake to btn_valid: 1 cycle. R handshake to awvalid/wvalid: 1 cycle.
- Valids never deassert before their ready handshake (AXI rule); addresses and data stable while valid.
- Simultaneous awready and wready in one cycle: both accepted; bready is asserted next cycle.
- bvalid arriving in the same cycle as the last AW/W handshake is held off by bready=0 and accepted one cycle later.
- Reset mid-transaction: all outputs return to reset values on the next edge, with no draining of outstanding responses. The interconnect/slave shares areset.
- Minimum poll period = POLL_CYCLES plus the handshake latencies; rounds never overlap.

## Configuration
- GPIO_POLL_CHANGE_ONLY_EN defined: WR is skipped (RD_DATA -> IDLE) when led_data equals the last value written with OKAY BRESP; the first round after reset always writes. A non-OKAY write leaves the stored value unchanged, so the write retries on the next round.
- Undefined: GPIO_DATA is written every round.

## Test plan
- Reset release, slave with ready always high -> AW 0x4000_0004/W 0x0 then AW 0x4000_000C/W 0xFFFF_FFFF; init_done=1 after the second B.
- POLL_CYCLES=4, enable=1, slave rdata=0x0000_0005, led_data=0xAB -> AR 0x4000_0008, btn_data=0x5 with a 1-cycle btn_valid, then AW 0x4000_0000/W 0xAB; repeats every round.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid holds 3; bready rises only after both handshakes complete.
- RRESP=SLVERR (2'b10) with rdata=0x7 -> err=1 and stays 1, btn_data keeps its prior value, no btn_valid, write still issued.
- enable=0 for 50 cycles after init -> no AR/AW issued. Assert areset during RD_DATA -> next cycle all valids 0 and state INIT_TRI1; after release, the TRI writes re-issue.
- With GPIO_POLL_CHANGE_ONLY_EN, led_data constant 0xAB for 3 rounds -> exactly one GPIO_DATA write. Change to 0x55 -> one more write.
